counter_ce_ctrl: RTL and testbench

//   Conditions two raw push-buttons and drives the ce input of the LED counter.

---
 rtl/counter_ctrl_pkg.sv | 19 +
 rtl/button_conditioner.sv | 55 +++++
 rtl/counter_ce_ctrl.sv | 100 ++++++++++
 tb/tb_counter_ce_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the push-button ce controller: FSM state encoding,
// default PYNQ timing constants and a counter-width helper.
package counter_ctrl_pkg;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } ctrl_state_e;

  localparam int CLK_HZ             = 125_000_000;
  localparam int SAMPLE_CNT_MAX_DEF = 62_500;  // 0.5 ms between debounce samples
  localparam int PULSE_CNT_MAX_DEF  = 200;     // 200 samples -> 100 ms stable press

  // Bits needed to hold values 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// One raw button in, one single-cycle rise pulse out: 2-flop synchroniser,
// tick-sampled saturating debounce counter, and rising-edge detector.
module button_conditioner
  import counter_ctrl_pkg::*;
#(
  parameter int PULSE_CNT_MAX = PULSE_CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic rise
);

  localparam int DW = cnt_width(PULSE_CNT_MAX);
  localparam logic [DW-1:0] CNT_SAT = DW'(PULSE_CNT_MAX);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_cnt;
  logic          r_deb_q;
  logic          w_synced;
  logic          w_deb;

  assign w_synced = r_sync[1];
  assign w_deb    = (r_cnt == CNT_SAT);
  assign rise     = w_deb & ~r_deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], btn};
    end
  end

  // Release clears immediately; only a sustained press is filtered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_synced) begin
      r_cnt <= '0;
    end else if (tick && (r_cnt != CNT_SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_q <= 1'b0;
    end else begin
      r_deb_q <= w_deb;
    end
  end

endmodule

// File: rtl/counter_ce_ctrl.sv
// Turns the run/pause and single-step buttons into the counter's clock enable,
// plus a RUN status flag for the LED.
module counter_ce_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF,
  parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run,
  input  logic btn_step,
  output logic ce,
  output logic running
);

  localparam int SW = cnt_width(SAMPLE_CNT_MAX - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);

  logic [SW-1:0] r_sample_cnt;
  logic          w_tick;
  logic          w_run_rise;
  logic          w_step_rise;
  ctrl_state_e   r_state;
  logic          r_ce;
  logic          r_running;

  assign w_tick = (r_sample_cnt == SAMPLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  button_conditioner #(
    .PULSE_CNT_MAX (PULSE_CNT_MAX)
  ) u_run_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .btn   (btn_run),
    .rise  (w_run_rise)
  );

  button_conditioner #(
    .PULSE_CNT_MAX (PULSE_CNT_MAX)
  ) u_step_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .btn   (btn_step),
    .rise  (w_step_rise)
  );

  // Run has priority over step; step only matters while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PAUSED;
      r_ce      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      unique case (r_state)
        PAUSED: begin
          if (w_run_rise) begin
            r_state   <= RUNNING;
            r_ce      <= 1'b1;
            r_running <= 1'b1;
          end else begin
            r_ce      <= w_step_rise;
            r_running <= 1'b0;
          end
        end
        RUNNING: begin
          if (w_run_rise) begin
            r_state   <= PAUSED;
            r_ce      <= 1'b0;
            r_running <= 1'b0;
          end else begin
            r_ce      <= 1'b1;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= PAUSED;
          r_ce      <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign ce      = r_ce;
  assign running = r_running;

endmodule

// File: tb/tb_counter_ce_ctrl.sv
// Scoreboard bench for counter_ce_ctrl: directed button scenarios plus random
// press/bounce traffic, compared cycle by cycle against a press-event model.
module tb_counter_ce_ctrl;

  localparam int S = 4;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic ce;
  logic running;

  always #5 clk = ~clk;

  counter_ce_ctrl #(
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .ce       (ce),
    .running  (running)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_q[$];

  // Model: pins reach the logic two edges late; a press is accepted once the
  // delayed level has been seen high on P sample ticks in a row, and the
  // accepted press acts on the FSM one edge later.
  int m_cycle;
  bit m_dly_r[2];
  bit m_dly_s[2];
  int m_held_r, m_held_s;
  bit m_press_r, m_press_s;
  bit m_running, m_ce;

  int ce_cnt, ce_paused_cnt, ce_low_run_cnt, run_tog_cnt;
  logic prev_run;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_cycle   = 0;
    m_dly_r   = '{0, 0};
    m_dly_s   = '{0, 0};
    m_held_r  = 0;
    m_held_s  = 0;
    m_press_r = 0;
    m_press_s = 0;
    m_running = 0;
    m_ce      = 0;
  endfunction

  function automatic void model_edge(input bit pin_r, input bit pin_s);
    bit sampling, lvl_r, lvl_s, act_r, act_s;
    sampling = ((m_cycle % S) == S - 1);
    lvl_r = m_dly_r[1];
    lvl_s = m_dly_s[1];
    act_r = m_press_r;
    act_s = m_press_s;
    m_press_r = 0;
    m_press_s = 0;
    if (!lvl_r) m_held_r = 0;
    else if (sampling && m_held_r < P) begin
      m_held_r++;
      m_press_r = (m_held_r == P);
    end
    if (!lvl_s) m_held_s = 0;
    else if (sampling && m_held_s < P) begin
      m_held_s++;
      m_press_s = (m_held_s == P);
    end
    m_dly_r[1] = m_dly_r[0];
    m_dly_r[0] = pin_r;
    m_dly_s[1] = m_dly_s[0];
    m_dly_s[0] = pin_s;
    m_cycle++;
    if (act_r) begin
      m_running = !m_running;
      m_ce      = m_running;
    end else begin
      m_ce = m_running || act_s;
    end
    exp_q.push_back({m_ce, m_running});
  endfunction

  task automatic cycle(input bit r, input bit s);
    btn_run  = r;
    btn_step = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
  endtask

  task automatic hold(input bit r, input bit s, input int n);
    repeat (n) cycle(r, s);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_ce_async"}, ce, 0);
    chk({tag, "_running_async"}, running, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_ce", ce, e[1]);
      chk("sb_running", running, e[0]);
    end
    if (rst_n) begin
      if (ce === 1'b1) ce_cnt++;
      if (ce === 1'b1 && running === 1'b0) ce_paused_cnt++;
      if (ce === 1'b0 && running === 1'b1) ce_low_run_cnt++;
      if (running !== prev_run) run_tog_cnt++;
    end
    prev_run = running;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, c0, p0, l0, t0;
    bit r, s;
    ce_cnt = 0; ce_paused_cnt = 0; ce_low_run_cnt = 0; run_tog_cnt = 0;
    prev_run = 1'b0;
    model_reset();

    // Power-on reset, then a mid-cycle reset with idle buttons.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(0, 0, 5);
    do_reset("rst_idle");
    hold(0, 0, 20);
    chk("rst_idle_ce_after20", ce, 0);
    chk("rst_idle_run_after20", running, 0);

    // Run toggle: press, latency bound, one transition per press.
    t0 = run_tog_cnt;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0);
      if (ce === 1'b1 && first < 0) first = i + 1;
    end
    chk("run_press_latency_ok", (first > 0 && first <= 18), 1);
    hold(0, 0, 30);
    chk("run_on_ce", ce, 1);
    chk("run_on_running", running, 1);
    chk("run_on_one_transition", run_tog_cnt - t0, 1);
    t0 = run_tog_cnt;
    hold(1, 0, 30);
    hold(0, 0, 30);
    chk("run_off_ce", ce, 0);
    chk("run_off_running", running, 0);
    chk("run_off_one_transition", run_tog_cnt - t0, 1);

    // Bounce never qualifies; a stable press afterwards does.
    c0 = ce_cnt;
    for (int i = 0; i < 40; i++) cycle(((i / 3) % 2) == 0, 0);
    hold(0, 0, 20);
    chk("bounce_no_ce", ce_cnt - c0, 0);
    hold(1, 0, 30);
    chk("bounce_then_stable_ce", ce, 1);
    hold(0, 0, 10);
    hold(1, 0, 30);
    hold(0, 0, 10);
    chk("bounce_back_paused", running, 0);

    // Single step while paused.
    c0 = ce_cnt;
    t0 = run_tog_cnt;
    hold(0, 1, 30);
    hold(0, 0, 20);
    chk("step_paused_one_pulse", ce_cnt - c0, 1);
    chk("step_paused_running_stays0", run_tog_cnt - t0, 0);

    // Step while running is ignored.
    hold(1, 0, 30);
    hold(0, 0, 10);
    l0 = ce_low_run_cnt;
    t0 = run_tog_cnt;
    hold(0, 1, 30);
    hold(0, 0, 20);
    chk("step_running_no_glitch", ce_low_run_cnt - l0, 0);
    chk("step_running_state_kept", run_tog_cnt - t0, 0);
    chk("step_running_ce", ce, 1);
    hold(1, 0, 30);
    hold(0, 0, 20);

    // Simultaneous presses: run wins, no step pulse first.
    p0 = ce_paused_cnt;
    t0 = run_tog_cnt;
    hold(1, 1, 30);
    hold(0, 0, 20);
    chk("simul_no_step_pulse", ce_paused_cnt - p0, 0);
    chk("simul_running", running, 1);
    chk("simul_one_transition", run_tog_cnt - t0, 1);
    hold(1, 0, 30);
    hold(0, 0, 20);

    // Reset during a held press forces a full re-debounce.
    hold(1, 0, 10);
    do_reset("rst_press");
    first = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 0);
      if (ce === 1'b1 && first < 0) first = i + 1;
    end
    chk("rst_press_redebounce_min", (first >= 12), 1);
    chk("rst_press_redebounce_max", (first > 0 && first <= 18), 1);
    hold(0, 0, 10);
    hold(1, 0, 30);
    hold(0, 0, 20);

    // Random traffic: clean presses, bouncy presses, occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      len = $urandom_range(1, 30);
      r = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < len; i++)
          cycle(r & ($urandom_range(0, 3) != 0), s & ($urandom_range(0, 3) != 0));
      end else begin
        hold(r, s, len);
      end
      if ($urandom_range(0, 11) == 0) do_reset("rst_rand");
      hold(0, 0, $urandom_range(0, 15));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
